encode_acq_ctrl: RTL

- Scan-acquisition controller in front of the encode interpolation datapath (W = rotary, X = linear encoder).
- Resets/flushes the interpolator at scan start, waits for the wafer zero point and skips a configured number of revolutions.
- Then gates the precise-encode stream to the downstream packer for N revolutions.
- Watches encoder updates with a timeout and reports busy/done/fault status to the register block.

---
 rtl/encode_pkg.sv | 26 ++
 rtl/encode_acq_ctrl_if.sv | 16 +
 rtl/encode_update_watchdog.sv | 44 ++++
 rtl/encode_acq_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/encode_pkg.sv
// Shared definitions for the encode acquisition controller slice.
// Holds the controller state encoding and the default widths used as
// parameter defaults by the interface, the watchdog and the top level.
package encode_pkg;

   localparam int ENCODE_WID_DEF     = 32;
   localparam int REV_CNT_WID_DEF    = 16;
   localparam int SAMPLE_CNT_WID_DEF = 32;
   localparam int TIMEOUT_WID_DEF    = 24;
   localparam int FLUSH_CYC_DEF      = 4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FLUSH     = 3'd1,
      ST_WAIT_ZERO = 3'd2,
      ST_ACQ       = 3'd3,
      ST_DONE      = 3'd4,
      ST_FAULT     = 3'd5
   } acq_state_e;

   // Busy covers every state where a scan is in progress.
   function automatic logic state_is_busy(acq_state_e s);
      return (s == ST_FLUSH) || (s == ST_WAIT_ZERO) || (s == ST_ACQ);
   endfunction

endpackage

// File: rtl/encode_acq_ctrl_if.sv
// Encode sample stream: one valid strobe plus the W (rotary) and X
// (linear) positions.
//   master : drives vld, w, x
//   slave  : receives vld, w, x
interface encode_acq_ctrl_if
   import encode_pkg::*;
#(
   parameter int ENCODE_WID = ENCODE_WID_DEF
);
   logic                  vld;
   logic [ENCODE_WID-1:0] w;
   logic [ENCODE_WID-1:0] x;

   modport master (output vld, w, x);
   modport slave  (input  vld, w, x);
endinterface

// File: rtl/encode_update_watchdog.sv
// Encoder update watchdog. Counts cycles since the last encoder update
// while enabled and flags expiry on the cycle the count would reach the
// limit. An update in that same cycle suppresses expiry and restarts the
// count. A zero limit disables expiry. The count saturates.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   cnt_en_i     : count enable (scan waiting for zero or acquiring)
//   clr_i        : clear at scan start
//   update_i     : raw encoder update strobe, clears the count
//   limit_i      : timeout limit in cycles (0 = disabled)
//   expire_o     : combinational expiry flag
module encode_update_watchdog
   import encode_pkg::*;
#(
   parameter int TIMEOUT_WID = TIMEOUT_WID_DEF
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cnt_en_i,
   input  logic                   clr_i,
   input  logic                   update_i,
   input  logic [TIMEOUT_WID-1:0] limit_i,
   output logic                   expire_o
);

   logic [TIMEOUT_WID-1:0] cnt_q;
   logic [TIMEOUT_WID:0]   cnt_inc;

   // One bit wider so the compare against an all-ones limit stays exact.
   assign cnt_inc  = {1'b0, cnt_q} + (TIMEOUT_WID+1)'(1);
   assign expire_o = cnt_en_i && !update_i && (limit_i != '0) &&
                     (cnt_inc == {1'b0, limit_i});

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (clr_i || update_i) begin
         cnt_q <= '0;
      end else if (cnt_en_i && !(&cnt_q)) begin
         cnt_q <= cnt_inc[TIMEOUT_WID-1:0];
      end
   end

endmodule

// File: rtl/encode_acq_ctrl.sv
// Scan-acquisition controller in front of the encode interpolation path.
// Flushes the interpolator at scan start, waits for the first wafer zero
// point, skips cfg_skip_rev revolutions, then forwards the precise encode
// stream for cfg_rev_num revolutions. An encoder-update watchdog moves the
// scan to FAULT when updates stop.
// Build option: define ENCODE_ACQ_X_LIMIT_EN to also end the scan once a
// forwarded sample reaches the latched X end position.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start_i, stop_i     : scan start (IDLE/FAULT only) and abort pulses
//   cfg_*_i             : scan configuration, latched at start
//   encode_update_i     : raw encoder update strobe (watchdog)
//   wafer_zero_flag_i   : zero-point flag, rising edge marks a revolution
//   precise_if          : interpolated sample stream in
//   acq_if              : forwarded sample stream out (latency 1)
//   interp_rst_o        : interpolator reset (rst_i or FLUSH)
//   acq_busy_o/done/fault : status to the register block
//   rev_cnt_o, sample_cnt_o : revolution and forwarded-sample counters
module encode_acq_ctrl
   import encode_pkg::*;
#(
   parameter int ENCODE_WID     = ENCODE_WID_DEF,
   parameter int REV_CNT_WID    = REV_CNT_WID_DEF,
   parameter int SAMPLE_CNT_WID = SAMPLE_CNT_WID_DEF,
   parameter int TIMEOUT_WID    = TIMEOUT_WID_DEF,
   parameter int FLUSH_CYC      = FLUSH_CYC_DEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      stop_i,
   input  logic [REV_CNT_WID-1:0]    cfg_skip_rev_i,
   input  logic [REV_CNT_WID-1:0]    cfg_rev_num_i,
   input  logic [TIMEOUT_WID-1:0]    cfg_timeout_i,
   input  logic [ENCODE_WID-1:0]     cfg_x_end_i,
   input  logic                      encode_update_i,
   input  logic                      wafer_zero_flag_i,
   encode_acq_ctrl_if.slave          precise_if,
   encode_acq_ctrl_if.master         acq_if,
   output logic                      interp_rst_o,
   output logic                      acq_busy_o,
   output logic                      acq_done_o,
   output logic                      acq_fault_o,
   output logic [REV_CNT_WID-1:0]    rev_cnt_o,
   output logic [SAMPLE_CNT_WID-1:0] sample_cnt_o
);

   localparam int FCW = $clog2(FLUSH_CYC + 1);

   acq_state_e state_q, state_d;

   logic [FCW-1:0]            flush_cnt_q;
   logic                      zero_d_q;
   logic [REV_CNT_WID-1:0]    skip_q, rev_num_q, rev_cnt_q;
   logic [TIMEOUT_WID-1:0]    timeout_q;
   logic [SAMPLE_CNT_WID-1:0] sample_cnt_q;
   logic                      vld_q;
   logic [ENCODE_WID-1:0]     w_q, x_q;

   logic                      zero_rise, start_ok, cnt_en, expire;
   logic                      in_window, rev_end, fwd, x_hit;
   logic [REV_CNT_WID-1:0]    rev_inc;
   logic [REV_CNT_WID:0]      end_rev;

   assign zero_rise = wafer_zero_flag_i && !zero_d_q;
   assign start_ok  = start_i && !stop_i &&
                      ((state_q == ST_IDLE) || (state_q == ST_FAULT));
   assign cnt_en    = (state_q == ST_WAIT_ZERO) || (state_q == ST_ACQ);

   assign rev_inc   = (&rev_cnt_q) ? rev_cnt_q : rev_cnt_q + REV_CNT_WID'(1);
   // Window end computed one bit wide so skip+rev_num cannot wrap.
   assign end_rev   = {1'b0, skip_q} + {1'b0, rev_num_q};
   assign in_window = ({1'b0, rev_cnt_q} >= {1'b0, skip_q}) &&
                      ({1'b0, rev_cnt_q} <  end_rev);
   assign rev_end   = zero_rise && ({1'b0, rev_inc} == end_rev);

   // The sample on the closing zero edge, an abort cycle or a timeout
   // cycle is dropped.
   assign fwd = (state_q == ST_ACQ) && precise_if.vld && in_window &&
                !rev_end && !stop_i && !expire;

`ifdef ENCODE_ACQ_X_LIMIT_EN
   logic [ENCODE_WID-1:0] x_end_q;
   assign x_hit = fwd && (precise_if.x >= x_end_q);

   always_ff @(posedge clk_i) begin
      if (rst_i)         x_end_q <= '0;
      else if (start_ok) x_end_q <= cfg_x_end_i;
   end
`else
   wire unused_x_end = ^cfg_x_end_i;
   assign x_hit = 1'b0;
`endif

   encode_update_watchdog #(
      .TIMEOUT_WID (TIMEOUT_WID)
   ) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .cnt_en_i (cnt_en),
      .clr_i    (start_ok),
      .update_i (encode_update_i),
      .limit_i  (timeout_q),
      .expire_o (expire)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (stop_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:      if (start_i) state_d = ST_FLUSH;
            ST_FLUSH:     if (flush_cnt_q == FCW'(FLUSH_CYC - 1)) state_d = ST_WAIT_ZERO;
            ST_WAIT_ZERO: begin
               if (expire)         state_d = ST_FAULT;
               else if (zero_rise) state_d = (end_rev == '0) ? ST_DONE : ST_ACQ;
            end
            ST_ACQ: begin
               if (expire)                state_d = ST_FAULT;
               else if (rev_end || x_hit) state_d = ST_DONE;
            end
            ST_DONE:      state_d = ST_IDLE;
            ST_FAULT:     if (start_i) state_d = ST_FLUSH;
            default:      state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         flush_cnt_q  <= '0;
         zero_d_q     <= 1'b0;
         skip_q       <= '0;
         rev_num_q    <= '0;
         timeout_q    <= '0;
         rev_cnt_q    <= '0;
         sample_cnt_q <= '0;
         vld_q        <= 1'b0;
         w_q          <= '0;
         x_q          <= '0;
      end else begin
         zero_d_q    <= wafer_zero_flag_i;
         flush_cnt_q <= (state_q == ST_FLUSH) ? flush_cnt_q + FCW'(1) : '0;
         if (start_ok) begin
            skip_q       <= cfg_skip_rev_i;
            rev_num_q    <= cfg_rev_num_i;
            timeout_q    <= cfg_timeout_i;
            rev_cnt_q    <= '0;
            sample_cnt_q <= '0;
         end else begin
            if ((state_q == ST_ACQ) && zero_rise && !stop_i && !expire)
               rev_cnt_q <= rev_inc;
            if (fwd && !(&sample_cnt_q))
               sample_cnt_q <= sample_cnt_q + SAMPLE_CNT_WID'(1);
         end
         vld_q <= fwd;
         if (fwd) begin
            w_q <= precise_if.w;
            x_q <= precise_if.x;
         end
      end
   end

   assign acq_if.vld   = vld_q;
   assign acq_if.w     = w_q;
   assign acq_if.x     = x_q;
   assign interp_rst_o = rst_i || (state_q == ST_FLUSH);
   assign acq_busy_o   = state_is_busy(state_q);
   assign acq_done_o   = (state_q == ST_DONE);
   assign acq_fault_o  = (state_q == ST_FAULT);
   assign rev_cnt_o    = rev_cnt_q;
   assign sample_cnt_o = sample_cnt_q;

endmodule
